// File: rtl/spi_txn_pkg.sv
// Shared types and constants for the SPI transaction slave: FSM states,
// transfer width codes and frame field lengths.
package spi_txn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_RWAIT,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_IDLE = 2'b11;

  localparam int HDR_BITS  = 16;
  localparam int TURN_BITS = 8;

  // Number of payload bits carried by a width code; 11 is treated as a word.
  function automatic logic [5:0] width_bits(input logic [1:0] code);
    case (code)
      W_BYTE:  return 6'd8;
      W_HALF:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Loadable MSB-first shift register; load has priority over shift.
module spi_shift_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_txn_slave.sv
// SPI mode-0 slave that decodes a 16-bit header and turns each frame into a
// single register write strobe or a read request with turnaround and read-back.
module spi_txn_slave
  import spi_txn_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [REG_W-1:0]  data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [REG_W-1:0]  data_out,
  input  logic              data_ready
);

  state_t              state_reg;
  logic [5:0]          cnt_reg;
  logic                spi_clk_d_reg;
  logic                armed_reg;
  logic [1:0]          width_reg;
  logic [REG_W-1:0]    cap_reg;
  logic                miso_reg;
  logic [ADDR_W-1:0]   address_reg;
  logic [REG_W-1:0]    data_in_reg;
  logic [1:0]          data_write_n_reg;
  logic [1:0]          data_read_n_reg;

  logic                rise;
  logic                fall;
  logic [5:0]          nbits;
  logic                hdr_rw;
  logic [1:0]          hdr_width;
  logic                hdr_done;
  logic                take_ready;
  logic                turn_done;
  logic [REG_W-1:0]    cap_next;
  logic                sr_load;
  logic                sr_shift;
  logic [REG_W-1:0]    sr_din;
  logic [REG_W-1:0]    sr_q;

  function automatic logic [REG_W-1:0] mask_read(input logic [REG_W-1:0] d,
                                                 input logic [1:0] w);
    logic [REG_W-1:0] m;
    m = d;
    if (w != W_WORD) m[REG_W-1:16] = '0;
    if (w == W_BYTE) m[15:8] = '0;
    return m;
  endfunction

  assign rise      = spi_clk & ~spi_clk_d_reg;
  assign fall      = ~spi_clk & spi_clk_d_reg;
  assign nbits     = width_bits(width_reg);
  // Header fields are read one bit early: the last bit is still on MOSI.
  assign hdr_rw    = sr_q[14];
  assign hdr_width = (sr_q[8:7] == W_IDLE) ? W_WORD : sr_q[8:7];
  assign hdr_done  = (state_reg == S_HDR) && rise && (cnt_reg == 6'(HDR_BITS - 1));
  assign turn_done = (state_reg == S_TURN) && rise && (cnt_reg == 6'(TURN_BITS - 1));
  assign take_ready = ((state_reg == S_RWAIT) || (state_reg == S_TURN)) &&
                      (data_read_n_reg != W_IDLE) && data_ready;

  always_comb begin
    cap_next = cap_reg;
    if (take_ready) begin
      cap_next = mask_read(data_out, width_reg);
    end else if (turn_done && (data_read_n_reg != W_IDLE)) begin
      cap_next = '0;
    end
  end

  // One shift register serves both directions: it collects header and write
  // data, and is reloaded with the left-aligned capture for the read-back.
  always_comb begin
    sr_din = '0;
    if (turn_done) begin
      case (width_reg)
        W_BYTE:  sr_din = cap_next << (REG_W - 8);
        W_HALF:  sr_din = cap_next << (REG_W - 16);
        default: sr_din = cap_next;
      endcase
    end
  end

  assign sr_load  = (state_reg == S_IDLE) || (hdr_done && hdr_rw) || turn_done;
  assign sr_shift = (rise && ((state_reg == S_HDR) || (state_reg == S_WDATA))) ||
                    (fall && (state_reg == S_RDATA) && (cnt_reg != nbits));

  spi_shift_reg #(.W(REG_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .din   (sr_din),
    .shift (sr_shift),
    .sin   (spi_mosi),
    .q     (sr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      spi_clk_d_reg    <= 1'b0;
      armed_reg        <= 1'b0;
      width_reg        <= W_BYTE;
      cap_reg          <= '0;
      miso_reg         <= 1'b0;
      address_reg      <= '0;
      data_in_reg      <= '0;
      data_write_n_reg <= W_IDLE;
      data_read_n_reg  <= W_IDLE;
    end else begin
      spi_clk_d_reg <= spi_clk;
      if (spi_cs_n) begin
        // Deselect aborts whatever is in flight; it also arms the next frame.
        state_reg        <= S_IDLE;
        cnt_reg          <= '0;
        armed_reg        <= 1'b1;
        miso_reg         <= 1'b0;
        data_write_n_reg <= W_IDLE;
        data_read_n_reg  <= W_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (armed_reg) begin
              state_reg <= S_HDR;
              cnt_reg   <= '0;
              armed_reg <= 1'b0;
            end
          end
          S_HDR: begin
            if (rise) begin
              if (cnt_reg == 6'(HDR_BITS - 1)) begin
                address_reg <= {sr_q[ADDR_W-2:0], spi_mosi};
                width_reg   <= hdr_width;
                cnt_reg     <= '0;
                if (hdr_rw) begin
                  state_reg <= S_WDATA;
                end else begin
                  state_reg       <= S_RWAIT;
                  data_read_n_reg <= hdr_width;
                end
              end else begin
                cnt_reg <= cnt_reg + 6'd1;
              end
            end
          end
          S_WDATA: begin
            if (rise) begin
              if (cnt_reg == nbits - 6'd1) begin
                data_in_reg      <= {sr_q[REG_W-2:0], spi_mosi};
                data_write_n_reg <= width_reg;
                state_reg        <= S_DONE;
                cnt_reg          <= '0;
              end else begin
                cnt_reg <= cnt_reg + 6'd1;
              end
            end
          end
          S_RWAIT: begin
            cap_reg <= cap_next;
            if (take_ready) data_read_n_reg <= W_IDLE;
            state_reg <= S_TURN;
            cnt_reg   <= '0;
          end
          S_TURN: begin
            cap_reg <= cap_next;
            if (take_ready) data_read_n_reg <= W_IDLE;
            if (rise) begin
              if (turn_done) begin
                data_read_n_reg <= W_IDLE;
                state_reg       <= S_RDATA;
                cnt_reg         <= '0;
              end else begin
                cnt_reg <= cnt_reg + 6'd1;
              end
            end
          end
          S_RDATA: begin
            if (fall) begin
              if (cnt_reg == nbits) begin
                miso_reg  <= 1'b0;
                state_reg <= S_DONE;
                cnt_reg   <= '0;
              end else begin
                miso_reg <= sr_q[REG_W-1];
                cnt_reg  <= cnt_reg + 6'd1;
              end
            end
          end
          S_DONE: begin
            data_write_n_reg <= W_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso     = miso_reg;
  assign address      = address_reg;
  assign data_in      = data_in_reg;
  assign data_write_n = data_write_n_reg;
  assign data_read_n  = data_read_n_reg;

endmodule

// File: tb/tb_spi_txn_slave.sv
// Directed and randomized frames driven into spi_txn_slave and compared against
// expectations computed from the frame format and width rules.
module tb_spi_txn_slave;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out = 32'h0;
  logic        data_ready = 1'b0;

  int          passed = 0;
  int          failed = 0;
  int          total = 0;
  int          strobe_cnt = 0;
  logic [1:0]  strobe_val = 2'b11;
  logic [63:0] last_wdata = 64'h0;

  always #5 clk = ~clk;

  spi_txn_slave #(.ADDR_W(6), .REG_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  // Count every clock in which a write strobe is visible.
  always @(negedge clk) begin
    if (data_write_n !== 2'b11) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_val = data_write_n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] eff_code(input logic [1:0] code);
    return (code == 2'b11) ? 2'b10 : code;
  endfunction

  function automatic int nbits_of(input logic [1:0] code);
    return (code == 2'b00) ? 8 : (code == 2'b01) ? 16 : 32;
  endfunction

  function automatic logic [63:0] low_bits(input logic [63:0] v, input int nb);
    return v % (64'd1 << nb);
  endfunction

  // Master side: MSB first, sample MISO just before each rising edge.
  task automatic spi_xfer(input logic [63:0] bits, input int n, output logic [63:0] rx);
    rx = 64'h0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      tick(HALF);
      rx = {rx[62:0], spi_miso};
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic write_txn(input logic [15:0] hdr, input logic [31:0] wdata, input string tag);
    logic [1:0]  code;
    int          nb;
    logic [63:0] rx;
    code = eff_code(hdr[9:8]);
    nb = nbits_of(code);
    strobe_cnt = 0;
    spi_cs_n = 1'b0;
    tick(4);
    spi_xfer((64'(hdr) << nb) | low_bits(64'(wdata), nb), 16 + nb, rx);
    tick(4);
    last_wdata = low_bits(64'(wdata), nb);
    check({tag, ".addr"}, 64'(address), 64'(hdr[5:0]));
    check({tag, ".data_in"}, 64'(data_in), last_wdata);
    check({tag, ".strobes"}, 64'(strobe_cnt), 64'd1);
    check({tag, ".strobe_w"}, 64'(strobe_val), 64'(code));
    $display("write hdr=%04h data=%08h nb=%0d -> addr=%0h data_in=%08h", hdr, wdata, nb, address, data_in);
    spi_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic read_txn(input logic [15:0] hdr, input logic [31:0] rdata, input int delay,
                          input bit respond, input string tag);
    logic [1:0]  code;
    int          nb;
    int          seen;
    bit          bad;
    logic [63:0] rx;
    logic [63:0] exp;
    code = eff_code(hdr[9:8]);
    nb = nbits_of(code);
    strobe_cnt = 0;
    data_out = $urandom;
    spi_cs_n = 1'b0;
    tick(4);
    fork
      spi_xfer(64'(hdr) << (8 + nb), 24 + nb, rx);
      begin
        int waited;
        waited = 0;
        seen = 0;
        bad = 1'b0;
        while (data_read_n === 2'b11 && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        check({tag, ".rd_req"}, 64'(data_read_n), 64'(code));
        while (data_read_n !== 2'b11 && seen < 400) begin
          if (data_read_n !== code) bad = 1'b1;
          if (respond && seen == delay) begin
            data_ready = 1'b1;
            data_out = rdata;
          end
          @(negedge clk);
          data_ready = 1'b0;
          data_out = $urandom;
          seen++;
        end
        check({tag, ".rd_hold"}, 64'(bad), 64'd0);
        if (respond) check({tag, ".rd_len"}, 64'(seen), 64'(delay + 1));
      end
    join
    exp = respond ? low_bits(64'(rdata), nb) : 64'h0;
    check({tag, ".lead_zeros"}, rx >> nb, 64'h0);
    check({tag, ".miso"}, low_bits(rx, nb), exp);
    check({tag, ".miso_end"}, 64'(spi_miso), 64'd0);
    check({tag, ".rd_idle"}, 64'(data_read_n), 64'h3);
    check({tag, ".no_wr"}, 64'(strobe_cnt), 64'd0);
    $display("read hdr=%04h nb=%0d ready=%0d delay=%0d -> miso=%0h", hdr, nb, respond, delay, low_bits(rx, nb));
    spi_cs_n = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [63:0] rx;
    logic [15:0] hdr;

    tick(3);
    check("rst.miso", 64'(spi_miso), 64'd0);
    check("rst.addr", 64'(address), 64'd0);
    check("rst.data_in", 64'(data_in), 64'd0);
    check("rst.wr_n", 64'(data_write_n), 64'h3);
    check("rst.rd_n", 64'(data_read_n), 64'h3);
    rst = 1'b0;
    tick(4);

    write_txn(16'h8205, 32'hDEAD_BEEF, "word_wr");
    read_txn(16'h0003, 32'h1234_5678, 3, 1'b1, "byte_rd");
    read_txn(16'h0105, 32'hCAFE_F00D, 0, 1'b0, "half_rd_noready");

    // Deselect after 20 bits of a word write: no strobe, previous data kept.
    strobe_cnt = 0;
    spi_cs_n = 1'b0;
    tick(4);
    spi_xfer((64'h8205 << 4) | 64'hD, 20, rx);
    spi_cs_n = 1'b1;
    tick(2);
    check("abort.strobes", 64'(strobe_cnt), 64'd0);
    check("abort.data_in", 64'(data_in), last_wdata);
    check("abort.wr_n", 64'(data_write_n), 64'h3);
    $display("abort after 20 bits -> strobes=%0d", strobe_cnt);
    tick(4);
    write_txn(16'h8121, 32'h0000_5A3C, "post_abort_wr");

    for (int k = 0; k < 10; k++) begin
      hdr = 16'($urandom);
      if (hdr[15]) write_txn(hdr, $urandom, "rnd_wr");
      else read_txn(hdr, $urandom, int'($urandom_range(0, 20)), $urandom_range(0, 3) != 0, "rnd_rd");
    end

    // Reset during the read-back of a word read.
    data_ready = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
    fork
      spi_xfer(64'h022A << 18, 34, rx);
      begin
        int waited;
        waited = 0;
        while (data_read_n === 2'b11 && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        data_ready = 1'b1;
        data_out = 32'hFFFF_FFFF;
        @(negedge clk);
        data_ready = 1'b0;
      end
    join
    check("rdata.partial", low_bits(rx, 10), 64'h3FF);
    rst = 1'b1;
    #1;
    check("midrst.miso", 64'(spi_miso), 64'd0);
    check("midrst.addr", 64'(address), 64'd0);
    check("midrst.data_in", 64'(data_in), 64'd0);
    check("midrst.wr_n", 64'(data_write_n), 64'h3);
    check("midrst.rd_n", 64'(data_read_n), 64'h3);
    $display("reset during read-back -> miso=%0d addr=%0h", spi_miso, address);
    tick(2);
    rst = 1'b0;
    tick(2);
    // Chip select never went high after reset, so this frame must be ignored.
    strobe_cnt = 0;
    spi_xfer(64'h8011A5, 24, rx);
    tick(4);
    check("unarmed.strobes", 64'(strobe_cnt), 64'd0);
    check("unarmed.data_in", 64'(data_in), 64'd0);
    spi_cs_n = 1'b1;
    tick(4);
    write_txn(16'h8011, 32'h0000_00A5, "post_rst_wr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
